// File: rtl/pll_drp_pkg.sv
// Shared FSM encoding and timing constants for the PLL DRP reconfiguration block.
package pll_drp_pkg;

  typedef enum logic [2:0] {
    IDLE,
    RD_REQ,
    RD_WAIT,
    WR_REQ,
    WR_WAIT,
    NEXT,
    LOCK_WAIT
  } state_t;

  // A PLL can still report the lock it held before reset for a few cycles after release.
  localparam int BLANK_CYCLES = 4;

endpackage

// File: rtl/drp_timeout_counter.sv
// Saturating wait counter: cleared by load, counts while enabled, flags the final allowed
// cycle (expired) and the end of an optional hold-off window (armed).
module drp_timeout_counter #(
  parameter int LIMIT   = 64,
  parameter int HOLDOFF = 0
) (
  input  logic clk,
  input  logic rst,
  input  logic load,
  input  logic enable,
  output logic expired,
  output logic armed
);

  localparam int W = $clog2(LIMIT + 1);

  logic [W-1:0] count;

  // Stops at LIMIT-1 so the count never wraps while the owner sits in its wait state.
  always_ff @(posedge clk) begin
    if (rst || load)
      count <= '0;
    else if (enable && !expired)
      count <= count + W'(1);
  end

  assign expired = (count == W'(LIMIT - 1));

  generate
    if (HOLDOFF == 0) begin : g_nohold
      assign armed = 1'b1;
    end else begin : g_hold
      assign armed = (count >= W'(HOLDOFF));
    end
  endgenerate

endmodule

// File: rtl/pll_drp_reconfig.sv
// Read-modify-write sequencer for PLL DRP registers: holds the PLL in reset across a
// burst of masked writes, then releases it and waits for a fresh lock.
module pll_drp_reconfig
  import pll_drp_pkg::*;
#(
  parameter int DRP_ADDR_W   = 7,
  parameter int DRP_DATA_W   = 16,
  parameter int DRDY_TIMEOUT = 64,
  parameter int LOCK_TIMEOUT = 4096
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  req_valid,
  output logic                  req_ready,
  input  logic [DRP_ADDR_W-1:0] req_addr,
  input  logic [DRP_DATA_W-1:0] req_data,
  input  logic [DRP_DATA_W-1:0] req_keep,
  input  logic                  req_last,
  output logic [DRP_ADDR_W-1:0] drp_daddr,
  output logic [DRP_DATA_W-1:0] drp_di,
  output logic                  drp_den,
  output logic                  drp_dwe,
  input  logic [DRP_DATA_W-1:0] drp_do,
  input  logic                  drp_drdy,
  output logic                  pll_rst,
  input  logic                  pll_locked,
  output logic                  busy,
  output logic                  done,
  output logic                  err
);

  typedef struct packed {
    logic [DRP_ADDR_W-1:0] addr;
    logic [DRP_DATA_W-1:0] data;
    logic [DRP_DATA_W-1:0] keep;
    logic                  last;
  } req_t;

  state_t                state;
  req_t                  req_q;
  logic [DRP_DATA_W-1:0] merged;
  logic                  drdy_wait, drdy_exp, drdy_armed;
  logic                  lock_wait, lock_exp, lock_armed;

  assign merged    = (drp_do & req_q.keep) | (req_q.data & ~req_q.keep);
  assign drdy_wait = (state == RD_WAIT) || (state == WR_WAIT);
  assign lock_wait = (state == LOCK_WAIT);

  // Counters restart whenever their wait state is not active, so every entry starts at zero.
  drp_timeout_counter #(
    .LIMIT  (DRDY_TIMEOUT),
    .HOLDOFF(0)
  ) u_drdy_tmo (
    .clk    (clk),
    .rst    (rst),
    .load   (!drdy_wait),
    .enable (drdy_wait),
    .expired(drdy_exp),
    .armed  (drdy_armed)
  );

  drp_timeout_counter #(
    .LIMIT  (LOCK_TIMEOUT),
    .HOLDOFF(BLANK_CYCLES)
  ) u_lock_tmo (
    .clk    (clk),
    .rst    (rst),
    .load   (!lock_wait),
    .enable (lock_wait),
    .expired(lock_exp),
    .armed  (lock_armed)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= IDLE;
      req_q     <= '0;
      req_ready <= 1'b1;
      drp_daddr <= '0;
      drp_di    <= '0;
      drp_den   <= 1'b0;
      drp_dwe   <= 1'b0;
      pll_rst   <= 1'b0;
      busy      <= 1'b0;
      done      <= 1'b0;
      err       <= 1'b0;
    end else begin
      done <= 1'b0;
      case (state)
        IDLE, NEXT: begin
          if (req_valid) begin
            req_q     <= '{addr: req_addr, data: req_data, keep: req_keep, last: req_last};
            req_ready <= 1'b0;
            busy      <= 1'b1;
            err       <= 1'b0;
            pll_rst   <= 1'b1;
            drp_daddr <= req_addr;
            drp_den   <= 1'b1;
            drp_dwe   <= 1'b0;
            state     <= RD_REQ;
          end
        end
        RD_REQ: begin
          drp_den <= 1'b0;
          state   <= RD_WAIT;
        end
        RD_WAIT: begin
          if (drp_drdy && drdy_armed) begin
            drp_di  <= merged;
            drp_den <= 1'b1;
            drp_dwe <= 1'b1;
            state   <= WR_REQ;
          end else if (drdy_exp) begin
            err       <= 1'b1;
            pll_rst   <= 1'b0;
            busy      <= 1'b0;
            req_ready <= 1'b1;
            state     <= IDLE;
          end
        end
        WR_REQ: begin
          drp_den <= 1'b0;
          drp_dwe <= 1'b0;
          state   <= WR_WAIT;
        end
        WR_WAIT: begin
          if (drp_drdy && drdy_armed) begin
            if (req_q.last) begin
              pll_rst <= 1'b0;
              state   <= LOCK_WAIT;
            end else begin
              req_ready <= 1'b1;
              state     <= NEXT;
            end
          end else if (drdy_exp) begin
            err       <= 1'b1;
            pll_rst   <= 1'b0;
            busy      <= 1'b0;
            req_ready <= 1'b1;
            state     <= IDLE;
          end
        end
        LOCK_WAIT: begin
          // A lock seen on the final allowed cycle still counts as success.
          if (lock_armed && pll_locked) begin
            done      <= 1'b1;
            busy      <= 1'b0;
            req_ready <= 1'b1;
            state     <= IDLE;
          end else if (lock_exp) begin
            err       <= 1'b1;
            busy      <= 1'b0;
            req_ready <= 1'b1;
            state     <= IDLE;
          end
        end
        default: begin
          drp_den   <= 1'b0;
          drp_dwe   <= 1'b0;
          pll_rst   <= 1'b0;
          busy      <= 1'b0;
          req_ready <= 1'b1;
          state     <= IDLE;
        end
      endcase
    end
  end

endmodule
